// File: rtl/life_engine.sv
// Conway's Game of Life engine: ROWS x COLS register grid, B3/S23,
// optional toroidal wrap, generation counter, still-life/extinction halt.
module life_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 load,
  input  logic                 run,
  input  logic                 step,
  input  logic                 tick,
  input  logic                 wrap,
  output logic [ROWS*COLS-1:0] grid_out,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 stable,
  output logic                 extinct
);

  localparam int N = ROWS * COLS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [N-1:0]     grid_q, grid_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [1:0]       state_q, state_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;

  logic [N-1:0]     next_grid;
  logic             same;
  logic             evolve;

  // Neighbour indices are elaboration-time constants; only edge
  // validity depends on wrap at run time.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RU = (r + ROWS - 1) % ROWS;
      localparam int RD = (r + 1) % ROWS;
      localparam int CL = (c + COLS - 1) % COLS;
      localparam int CR = (c + 1) % COLS;

      logic       vu, vd, vl, vr;
      logic [7:0] nb;
      logic [3:0] cnt;

      assign vu = wrap | (r != 0);
      assign vd = wrap | (r != ROWS - 1);
      assign vl = wrap | (c != 0);
      assign vr = wrap | (c != COLS - 1);

      assign nb[0] = vu & vl & grid_q[RU*COLS+CL];
      assign nb[1] = vu & grid_q[RU*COLS+c];
      assign nb[2] = vu & vr & grid_q[RU*COLS+CR];
      assign nb[3] = vl & grid_q[r*COLS+CL];
      assign nb[4] = vr & grid_q[r*COLS+CR];
      assign nb[5] = vd & vl & grid_q[RD*COLS+CL];
      assign nb[6] = vd & grid_q[RD*COLS+c];
      assign nb[7] = vd & vr & grid_q[RD*COLS+CR];

      assign cnt = 4'($countones(nb));

      assign next_grid[r*COLS+c] =
        (cnt == 4'd3) |
        ((cnt == 4'd2) & grid_q[r*COLS+c]);
    end
  end

  assign same = (next_grid == grid_q);

  always_comb begin
    grid_d    = grid_q;
    gen_d     = gen_q;
    state_d   = state_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    evolve    = 1'b0;
    if (load) begin
      grid_d    = seed;
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
      state_d   = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          evolve = step;
          if (run) state_d = S_RUN;
        end
        S_RUN: begin
          if (!run) begin
            state_d = S_IDLE;
          end else if (tick) begin
            evolve = 1'b1;
            if (same) state_d = S_HALT;
          end
        end
        S_HALT: begin
          if (!run) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (evolve) begin
        if (!same) begin
          grid_d    = next_grid;
          gen_d     = (gen_q == {GEN_W{1'b1}}) ?
                      gen_q : gen_q + GEN_W'(1);
          stable_d  = 1'b0;
          extinct_d = 1'b0;
        end else begin
          stable_d  = 1'b1;
          extinct_d = ~|grid_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grid_q    <= '0;
      gen_q     <= '0;
      state_q   <= S_IDLE;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      state_q   <= state_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
    end
  end

  assign grid_out  = grid_q;
  assign gen_count = gen_q;
  assign running   = (state_q == S_RUN);
  assign stable    = stable_q;
  assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: 8x8 (GEN_W 16 and 2) and 4x6 builds
// share control inputs.
module tb_life_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, load, run, step, tick, wrap;
  logic [63:0] seed;
  logic [23:0] seed2;

  logic [63:0] g0, g1;
  logic [23:0] g2;
  logic [15:0] gc0, gc2;
  logic [1:0]  gc1;
  logic        r0, s0, e0, r1, s1, e1, r2, s2, e2;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_0000_0E00;
  localparam logic [63:0] BLINK_V = 64'h0000_0000_0004_0404;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0006_0600;

  life_engine #(.ROWS(8), .COLS(8), .GEN_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .seed(seed), .load(load),
    .run(run), .step(step), .tick(tick), .wrap(wrap),
    .grid_out(g0), .gen_count(gc0), .running(r0),
    .stable(s0), .extinct(e0)
  );

  life_engine #(.ROWS(8), .COLS(8), .GEN_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .seed(seed), .load(load),
    .run(run), .step(step), .tick(tick), .wrap(wrap),
    .grid_out(g1), .gen_count(gc1), .running(r1),
    .stable(s1), .extinct(e1)
  );

  life_engine #(.ROWS(4), .COLS(6), .GEN_W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .seed(seed2), .load(load),
    .run(run), .step(step), .tick(tick), .wrap(wrap),
    .grid_out(g2), .gen_count(gc2), .running(r2),
    .stable(s2), .extinct(e2)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] s);
    seed = s;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    load = 0; run = 0; step = 0; tick = 0; wrap = 0;
    seed = '0; seed2 = '0;
    #12;
    checks++;
    if ({g0, gc0, r0, s0, e0} !== '0) begin
      errors++;
      $display("FAIL reset_dut0 got g=%h gc=%0d r=%b s=%b e=%b want 0",
               g0, gc0, r0, s0, e0);
    end
    checks++;
    if ({g2, gc2, r2, s2, e2, g1, gc1} !== '0) begin
      errors++;
      $display("FAIL reset_others got g2=%h gc2=%0d g1=%h gc1=%0d want 0",
               g2, gc2, g1, gc1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_blinker;
    wrap = 1'b0;
    do_load(BLINK_H);
    checks++;
    if (g0 !== BLINK_H || gc0 !== 16'd0) begin
      errors++;
      $display("FAIL blink_load got g=%h gc=%0d want g=%h gc=0",
               g0, gc0, BLINK_H);
    end
    step = 1'b1; cyc(); step = 1'b0;
    checks++;
    if (g0 !== BLINK_V || gc0 !== 16'd1 || s0 !== 1'b0) begin
      errors++;
      $display("FAIL blink_step1 got g=%h gc=%0d s=%b want g=%h gc=1 s=0",
               g0, gc0, s0, BLINK_V);
    end
    step = 1'b1; cyc(); step = 1'b0;
    checks++;
    if (g0 !== BLINK_H || gc0 !== 16'd2) begin
      errors++;
      $display("FAIL blink_step2 got g=%h gc=%0d want g=%h gc=2",
               g0, gc0, BLINK_H);
    end
  endtask

  task automatic test_block;
    do_load(BLOCK);
    run = 1'b1; tick = 1'b1;
    cyc();
    checks++;
    if (r0 !== 1'b1 || gc0 !== 16'd0 || s0 !== 1'b0) begin
      errors++;
      $display("FAIL block_enter_run got r=%b gc=%0d s=%b want 1 0 0",
               r0, gc0, s0);
    end
    cyc();
    checks++;
    if (s0 !== 1'b1 || e0 !== 1'b0 || r0 !== 1'b0 ||
        gc0 !== 16'd0 || g0 !== BLOCK) begin
      errors++;
      $display("FAIL block_halt got s=%b e=%b r=%b gc=%0d g=%h",
               s0, e0, r0, gc0, g0);
    end
    cyc(); cyc();
    checks++;
    if (r0 !== 1'b0 || g0 !== BLOCK || gc0 !== 16'd0 || s0 !== 1'b1) begin
      errors++;
      $display("FAIL block_frozen got r=%b g=%h gc=%0d s=%b",
               r0, g0, gc0, s0);
    end
    run = 1'b0; tick = 1'b0;
    cyc();
    run = 1'b1;
    cyc();
    checks++;
    if (r0 !== 1'b1) begin
      errors++;
      $display("FAIL block_idle_rerun got running=%b want 1", r0);
    end
    run = 1'b0;
    cyc();
  endtask

  task automatic test_wrap;
    wrap = 1'b1;
    do_load(64'h83);
    step = 1'b1; cyc(); step = 1'b0;
    checks++;
    if (g0 !== 64'h0100_0000_0000_0101 || gc0 !== 16'd1) begin
      errors++;
      $display("FAIL wrap_on got g=%h gc=%0d want g=0100000000000101 gc=1",
               g0, gc0);
    end
    wrap = 1'b0;
    do_load(64'h83);
    step = 1'b1; cyc(); step = 1'b0;
    checks++;
    if (g0 !== 64'd0 || gc0 !== 16'd1 || s0 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_off got g=%h gc=%0d s=%b want 0 1 0",
               g0, gc0, s0);
    end
    step = 1'b1; cyc(); step = 1'b0;
    checks++;
    if (s0 !== 1'b1 || e0 !== 1'b1 || gc0 !== 16'd1) begin
      errors++;
      $display("FAIL extinct got s=%b e=%b gc=%0d want 1 1 1",
               s0, e0, gc0);
    end
  endtask

  task automatic test_priority;
    wrap = 1'b0;
    do_load(BLINK_H);
    run = 1'b1; tick = 1'b1;
    cyc();
    cyc();
    seed = BLOCK; load = 1'b1;
    cyc();
    load = 1'b0;
    checks++;
    if (g0 !== BLOCK || gc0 !== 16'd0 || r0 !== 1'b0) begin
      errors++;
      $display("FAIL load_prio got g=%h gc=%0d r=%b want g=%h 0 0",
               g0, gc0, r0, BLOCK);
    end
    do_load(BLINK_H);
    cyc();
    run = 1'b0;
    cyc();
    checks++;
    if (g0 !== BLINK_H || gc0 !== 16'd0 || r0 !== 1'b0) begin
      errors++;
      $display("FAIL run_fall got g=%h gc=%0d r=%b want g=%h 0 0",
               g0, gc0, r0, BLINK_H);
    end
    tick = 1'b0; run = 1'b1; step = 1'b1;
    cyc();
    step = 1'b0;
    checks++;
    if (g0 !== BLINK_V || gc0 !== 16'd1 || r0 !== 1'b1) begin
      errors++;
      $display("FAIL run_step got g=%h gc=%0d r=%b want g=%h 1 1",
               g0, gc0, r0, BLINK_V);
    end
    tick = 1'b1;
    cyc();
    checks++;
    if (g0 !== BLINK_H || gc0 !== 16'd2) begin
      errors++;
      $display("FAIL run_tick got g=%h gc=%0d want g=%h 2",
               g0, gc0, BLINK_H);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({g0, gc0, r0, s0, e0} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run got g=%h gc=%0d r=%b want 0",
               g0, gc0, r0);
    end
    run = 1'b0; tick = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_saturation;
    logic [1:0] exp_gc [5];
    exp_gc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    wrap = 1'b0;
    do_load(BLINK_H);
    run = 1'b1; tick = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (gc1 !== exp_gc[i] ||
          g1 !== ((i % 2 == 0) ? BLINK_V : BLINK_H)) begin
        errors++;
        $display("FAIL saturate[%0d] got gc=%0d g=%h want gc=%0d",
                 i, gc1, g1, exp_gc[i]);
      end
    end
    run = 1'b0; tick = 1'b0;
    cyc();
  endtask

  task automatic test_nonsquare;
    wrap = 1'b1;
    seed2 = 24'h000380;
    do_load(64'd0);
    step = 1'b1; cyc(); step = 1'b0;
    checks++;
    if (g2 !== 24'h004104 || gc2 !== 16'd1) begin
      errors++;
      $display("FAIL nonsquare got g=%h gc=%0d want g=004104 gc=1",
               g2, gc2);
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_wrap();
    test_priority();
    test_saturation();
    test_nonsquare();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_engine.md
# life_engine

Parametrised Conway's Game of Life engine. It holds a ROWS×COLS cell grid in registers and evolves it by the B3/S23 rule, one generation per enabled tick or single-step request. The edge mode is selectable: toroidal wrap or dead boundary. It counts generations and detects still-life and extinction, halting on either. It sits between the seed/switch front end and the display driver; `tick` comes from the existing clock-divider enable.

## Interface
Parameters:
- ROWS, 8, grid rows (≥3)
- COLS, 8, grid columns (≥3)
- GEN_W, 16, generation counter width (≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- seed  in  ROWS*COLS  initial pattern; cell (r,c) at bit r*COLS+c
- load  in  1  pulse: copy seed into grid
- run  in  1  level: free-run, one generation per tick
- step  in  1  pulse: one generation (honoured in IDLE only)
- tick  in  1  generation-rate enable, used in RUN only
- wrap  in  1  1 = toroidal neighbours, 0 = out-of-range neighbours read as dead
- grid_out  out  ROWS*COLS  current grid (registered)
- gen_count  out  GEN_W  generations evolved since load, saturating
- running  out  1  state == RUN
- stable  out  1  last evaluated generation equalled the current grid
- extinct  out  1  stable and grid all-zero

## Operation
- Next-state logic is combinational over the whole grid:
  - 8-neighbour count per cell, 4-bit.
  - Next cell = (count==3) | (count==2 & cell).
  - wrap applies to row and column indices independently (mod ROWS, mod COLS).
- "Evolve" event:
  - If next != grid: grid <= next, gen_count +1 (holds at 2^GEN_W−1), stable <= 0, extinct <= 0.
  - If next == grid: grid and gen_count unchanged, stable <= 1, extinct <= (grid==0).
- FSM states: IDLE, RUN, HALT.
  - IDLE: run=1 → RUN. step=1 → evolve, stay IDLE.
  - RUN: run=0 → IDLE (no evolve that cycle). tick=1 → evolve; if that evolve set stable → HALT.
  - HALT: grid frozen, tick and step ignored; run=0 → IDLE.
- load has top priority in every state:
  - grid <= seed, gen_count <= 0, stable <= 0, extinct <= 0, state <= IDLE.
  - step, run and tick are ignored that cycle.
- wrap may change at any time and takes effect on the next evolve.

## Timing
- Reset (async assert, sync deassert handled upstream): grid_out=0, gen_count=0, state IDLE, running=0, stable=0, extinct=0.
- Latency: the evolve is sampled at edge N; grid_out, gen_count and flags are valid after edge N.
  - running reflects the state registered at edge N.
- Max rate: one generation per clock (tick held high).
- step held high in IDLE evolves every cycle; the upstream edge-detector makes it a single pulse.
- Simultaneous events:
  - load+step or load+tick: load only.
  - run=1 and step=1 in IDLE: step evolves and the state moves to RUN the same edge.
  - run falling in the same cycle as tick in RUN: no evolve.
- Reset mid-run: immediate clear to reset values regardless of state.
- An empty grid is a still life: the first evolve on an all-zero grid sets stable=1, extinct=1.

## Test plan
- **Blinker, 8×8, wrap=0.**
  - Stimulus: load seed bits {9,10,11}, then step.
  - Required: grid {2,10,18}, gen_count=1, stable=0.
  - Stimulus: step again. Required: {9,10,11}, gen_count=2.
- **Block still life.**
  - Stimulus: load {9,10,17,18}, run=1, tick=1.
  - Required: after the first tick, stable=1, extinct=0, state HALT, gen_count=0, grid unchanged.
  - Stimulus: further ticks. Required: no change. Stimulus: run=0. Required: IDLE.
- **Wrap mode.**
  - Stimulus: load {7,0,1}, wrap=1, step. Required: {56,0,8}.
  - Stimulus: reload, wrap=0, step. Required: grid 0, gen_count=1. Stimulus: step. Required: stable=1, extinct=1.
- **Priority.**
  - In RUN with tick=1, pulse load with a new seed. Required: grid=seed, gen_count=0, IDLE, no evolve that edge.
  - Run again, then assert reset_n=0 mid-run. Required: all outputs 0 immediately.
- **Saturation.**
  - Build with GEN_W=2 and free-run a blinker.
  - Required: gen_count reads 1,2,3,3,3 while the grid keeps oscillating.
- **Non-square build.**
  - Build with ROWS=4, COLS=6, wrap=1. Load {7,8,9} and step.
  - Required: {2,8,14}, gen_count=1.
